fetch_hazard_ctrl: RTL and testbench
====================================

Name: fetch_hazard_ctrl

Overview:
Sequencing controller for the fetch stage of the 5-stage pipelined CPU. Each cycle it decides whether the PC register advances, redirects (branch/jump) or holds, and whether the instruction register captures memory data. It resolves load-use stalls, data-memory busy freezes, instruction-memory wait states and post-redirect bubbles, and keeps saturating stall/flush performance counters.

Parameters:
REDIRECT_BUBBLES, 1, cycles of fetch discarded after a redirect (synchronous IMEM read latency); legal 1..3
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
imem_ready  in  1  instruction memory data valid this cycle
mem_busy  in  1  data memory stalling; freeze whole pipeline
ex_branch_taken  in  1  branch in EX resolved taken
id_jump  in  1  jump decoded in ID
ex_memread  in  1  EX instruction is a load
ex_rt  in  5  load destination register in EX
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
pc_write  out  1  PC register update enable
ir_write  out  1  instruction register capture enable
pc_src  out  1  select branch target into PC
jump  out  1  select jump target into PC
ifid_flush  out  1  replace IF/ID contents with NOP
idex_bubble  out  1  insert NOP into ID/EX
pipe_hold  out  1  freeze all pipeline registers
fsm_state  out  2  current state (debug): 0 RUN, 1 REDIRECT, 2 HOLD
stall_cnt  out  CNT_W  cycles with pc_write=0 since reset, saturating
flush_cnt  out  CNT_W  cycles with ifid_flush=1 since reset, saturating

Behaviour:
- Clock clk; reset rst is synchronous and active-high. While rst=1: every control output 0; counters 0; state <- REDIRECT with bubble counter = REDIRECT_BUBBLES, so the first IMEM word after reset is discarded.
- Control outputs are combinational from state, bubble counter and inputs (they act in the same cycle); state, bubble counter and perf counters are registered.
- load_use = ex_memread & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- Per-cycle priority, in any state (first match wins; unlisted outputs 0):
  1. mem_busy: pipe_hold=1, pc_write=0, ir_write=0. Next state HOLD; bubble counter preserved.
  2. ex_branch_taken: pc_write=1, pc_src=1, ifid_flush=1, idex_bubble=1. Next REDIRECT, bubble counter <- REDIRECT_BUBBLES.
  3. id_jump: pc_write=1, jump=1, ifid_flush=1. Next REDIRECT, bubble counter <- REDIRECT_BUBBLES.
  4. REDIRECT with bubble counter>0: pc_write=imem_ready, ifid_flush=1; counter decrements only when imem_ready=1; at 1 with imem_ready=1, next RUN.
  5. load_use: pc_write=0, ir_write=0, idex_bubble=1. Stall lasts every cycle load_use holds.
  6. !imem_ready: pc_write=0, ir_write=0, ifid_flush=1.
  7. Otherwise: pc_write=1, ir_write=1.
- HOLD: when mem_busy drops, returns to REDIRECT if the bubble counter is >0, else RUN. In-flight instructions are frozen, so the branch/jump inputs re-present and are handled normally afterwards.
- pc_src and jump never both 1. ir_write=1 only in rule 7.
- Counters: stall_cnt +1 each non-reset cycle with pc_write=0; flush_cnt +1 each cycle with ifid_flush=1. Both hold at 2^CNT_W-1 and do not wrap.

Test Plan:
- Reset then imem_ready=1, no hazards -> cycle 0 after reset: ifid_flush=1, pc_write=1, ir_write=0; cycle 1 onward: pc_write=ir_write=1, fsm_state=0; flush_cnt=1.
- ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 for one cycle -> that cycle pc_write=0, ir_write=0, idex_bubble=1; with ex_rt=0 -> no stall.
- ex_branch_taken=1 with id_jump=1 in the same cycle -> pc_src=1, jump=0, ifid_flush=idex_bubble=1; next cycle ifid_flush=1, ir_write=0; then RUN.
- mem_busy=1 for 3 cycles during REDIRECT (REDIRECT_BUBBLES=2, counter=1) -> pipe_hold=1 for 3 cycles, fsm_state=2, stall_cnt +3; then 1 discard cycle, then RUN.
- imem_ready=0 for 2 cycles in RUN -> pc_write=0, ifid_flush=1 both cycles; resumes with ir_write=1 when imem_ready returns.
- CNT_W=4, hold load_use for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage sequencing controller: decides each cycle whether the PC
// advances, redirects or holds, and whether the IR captures the IMEM word.
//
// Handshake / timing contract: all control outputs are combinational from
// the registered state, the bubble counter and the current inputs, and take
// effect in the same cycle. imem_ready qualifies the IMEM word presented this
// cycle; the word is consumed (ir_write=1) only when no hazard is active.
module fetch_hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ready,
    input  logic             mem_busy,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    output logic             pc_write,
    output logic             ir_write,
    output logic             pc_src,
    output logic             jump,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_REDIRECT = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    // Bubble counter only needs to cover 1..3 discarded fetches.
    localparam logic [1:0]       BUB_INIT = 2'(REDIRECT_BUBBLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       bub_q;
    logic [1:0]       bub_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic load_use;
    logic rs_hit;
    logic rt_hit;
    logic discarding;

    // Load-use hazard: ID needs the register a load in EX has not yet produced.
    always_comb begin
        rs_hit   = id_uses_rs && (id_rs == ex_rt);
        rt_hit   = id_uses_rt && (id_rt == ex_rt);
        load_use = ex_memread && (ex_rt != 5'd0) && (rs_hit || rt_hit);
    end

    // Post-redirect discard window; also applies on the cycle a HOLD releases
    // with bubbles still owed, so no stale fetch slips into IF/ID.
    always_comb begin
        discarding = (bub_q != 2'd0) &&
                     ((state_q == S_REDIRECT) || (state_q == S_HOLD));
    end

    // Next-state and control outputs, highest-priority hazard first.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        pc_src      = 1'b0;
        jump        = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        state_d     = state_q;
        bub_d       = bub_q;

        if (rst) begin
            // Outputs forced idle; state registers are reloaded in the flop.
            state_d = S_REDIRECT;
            bub_d   = BUB_INIT;
        end else if (mem_busy) begin
            // Whole pipeline frozen; remember how many bubbles are still owed.
            pipe_hold = 1'b1;
            state_d   = S_HOLD;
        end else if (ex_branch_taken) begin
            pc_write    = 1'b1;
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = S_REDIRECT;
            bub_d       = BUB_INIT;
        end else if (id_jump) begin
            pc_write   = 1'b1;
            jump       = 1'b1;
            ifid_flush = 1'b1;
            state_d    = S_REDIRECT;
            bub_d      = BUB_INIT;
        end else if (discarding) begin
            // The word arriving now was fetched from the old path: drop it.
            pc_write   = imem_ready;
            ifid_flush = 1'b1;
            state_d    = S_REDIRECT;
            if (imem_ready) begin
                bub_d = bub_q - 2'd1;
                if (bub_q == 2'd1) begin
                    state_d = S_RUN;
                end
            end
        end else if (load_use) begin
            idex_bubble = 1'b1;
            state_d     = S_RUN;
        end else if (!imem_ready) begin
            ifid_flush = 1'b1;
            state_d    = S_RUN;
        end else begin
            pc_write = 1'b1;
            ir_write = 1'b1;
            state_d  = S_RUN;
        end
    end

    // State and bubble counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REDIRECT;
            bub_q   <= BUB_INIT;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    // Saturating performance counters for stall and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (ifid_flush && (flush_q != CNT_MAX)) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

    assign fsm_state = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench for fetch_hazard_ctrl. Two instances share all inputs:
// dut_a uses the default parameters, dut_b uses REDIRECT_BUBBLES=2, CNT_W=4.
// Control vector order: {pc_write, ir_write, pc_src, jump, ifid_flush,
// idex_bubble, pipe_hold}.
module tb_fetch_hazard_ctrl;

    localparam logic [6:0] C_ZERO = 7'b0000000;
    localparam logic [6:0] C_RUN  = 7'b1100000;
    localparam logic [6:0] C_DISC = 7'b1000100;
    localparam logic [6:0] C_LU   = 7'b0000010;
    localparam logic [6:0] C_WAIT = 7'b0000100;
    localparam logic [6:0] C_BR   = 7'b1010110;
    localparam logic [6:0] C_JMP  = 7'b1001100;
    localparam logic [6:0] C_BUSY = 7'b0000001;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       imem_ready, mem_busy, ex_branch_taken, id_jump, ex_memread;
    logic       id_uses_rs, id_uses_rt;
    logic [4:0] ex_rt, id_rs, id_rt;

    logic        a_pc_write, a_ir_write, a_pc_src, a_jump, a_ifid_flush, a_idex_bubble, a_pipe_hold;
    logic [1:0]  a_fsm_state;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_write, b_ir_write, b_pc_src, b_jump, b_ifid_flush, b_idex_bubble, b_pipe_hold;
    logic [1:0]  b_fsm_state;
    logic [3:0]  b_stall_cnt, b_flush_cnt;
    logic [6:0]  a_ctl, b_ctl;

    assign a_ctl = {a_pc_write, a_ir_write, a_pc_src, a_jump, a_ifid_flush, a_idex_bubble, a_pipe_hold};
    assign b_ctl = {b_pc_write, b_ir_write, b_pc_src, b_jump, b_ifid_flush, b_idex_bubble, b_pipe_hold};

    int n_checks = 0;
    int n_pass   = 0;

    fetch_hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .mem_busy(mem_busy),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .pc_write(a_pc_write), .ir_write(a_ir_write), .pc_src(a_pc_src), .jump(a_jump),
        .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .pipe_hold(a_pipe_hold),
        .fsm_state(a_fsm_state), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    fetch_hazard_ctrl #(.REDIRECT_BUBBLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .mem_busy(mem_busy),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .pc_write(b_pc_write), .ir_write(b_ir_write), .pc_src(b_pc_src), .jump(b_jump),
        .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .pipe_hold(b_pipe_hold),
        .fsm_state(b_fsm_state), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_ready = 1'b1; mem_busy = 1'b0; ex_branch_taken = 1'b0; id_jump = 1'b0;
        ex_memread = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        mem_busy = 1'b1; id_jump = 1'b1;
        rst = 1'b1;
        tick(); tick();
        if (a_ctl !== C_ZERO) $display("FAIL reset_a_ctl got=%b exp=%b", a_ctl, C_ZERO); else n_pass++; n_checks++;
        if (b_ctl !== C_ZERO) $display("FAIL reset_b_ctl got=%b exp=%b", b_ctl, C_ZERO); else n_pass++; n_checks++;
        if (a_fsm_state !== 2'd1) $display("FAIL reset_a_state got=%0d exp=1", a_fsm_state); else n_pass++; n_checks++;
        if (a_stall_cnt !== 16'd0) $display("FAIL reset_a_stall got=%0d exp=0", a_stall_cnt); else n_pass++; n_checks++;
        if (a_flush_cnt !== 16'd0) $display("FAIL reset_a_flush got=%0d exp=0", a_flush_cnt); else n_pass++; n_checks++;
        if (b_stall_cnt !== 4'd0) $display("FAIL reset_b_stall got=%0d exp=0", b_stall_cnt); else n_pass++; n_checks++;
    endtask

    task automatic test_startup();
        idle();
        rst = 1'b0;
        #1;
        if (a_ctl !== C_DISC) $display("FAIL start_c0_a_ctl got=%b exp=%b", a_ctl, C_DISC); else n_pass++; n_checks++;
        if (b_ctl !== C_DISC) $display("FAIL start_c0_b_ctl got=%b exp=%b", b_ctl, C_DISC); else n_pass++; n_checks++;
        tick(); #1;
        if (a_ctl !== C_RUN) $display("FAIL start_c1_a_ctl got=%b exp=%b", a_ctl, C_RUN); else n_pass++; n_checks++;
        if (a_fsm_state !== 2'd0) $display("FAIL start_c1_a_state got=%0d exp=0", a_fsm_state); else n_pass++; n_checks++;
        if (b_ctl !== C_DISC) $display("FAIL start_c1_b_ctl got=%b exp=%b", b_ctl, C_DISC); else n_pass++; n_checks++;
        if (b_fsm_state !== 2'd1) $display("FAIL start_c1_b_state got=%0d exp=1", b_fsm_state); else n_pass++; n_checks++;
        tick(); #1;
        if (b_ctl !== C_RUN) $display("FAIL start_c2_b_ctl got=%b exp=%b", b_ctl, C_RUN); else n_pass++; n_checks++;
        if (a_flush_cnt !== 16'd1) $display("FAIL start_a_flush got=%0d exp=1", a_flush_cnt); else n_pass++; n_checks++;
        if (b_flush_cnt !== 4'd2) $display("FAIL start_b_flush got=%0d exp=2", b_flush_cnt); else n_pass++; n_checks++;
        if (a_stall_cnt !== 16'd0) $display("FAIL start_a_stall got=%0d exp=0", a_stall_cnt); else n_pass++; n_checks++;
        tick();
    endtask

    task automatic test_load_use();
        idle(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; #1;
        if (a_ctl !== C_LU) $display("FAIL lu_rs_a_ctl got=%b exp=%b", a_ctl, C_LU); else n_pass++; n_checks++;
        if (b_ctl !== C_LU) $display("FAIL lu_rs_b_ctl got=%b exp=%b", b_ctl, C_LU); else n_pass++; n_checks++;
        tick();
        ex_rt = 5'd0; id_rs = 5'd0; #1;
        if (a_ctl !== C_RUN) $display("FAIL lu_r0_a_ctl got=%b exp=%b", a_ctl, C_RUN); else n_pass++; n_checks++;
        tick();
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
        if (a_ctl !== C_LU) $display("FAIL lu_rt_a_ctl got=%b exp=%b", a_ctl, C_LU); else n_pass++; n_checks++;
        tick();
        id_uses_rt = 1'b0; #1;
        if (a_ctl !== C_RUN) $display("FAIL lu_rtunused_a_ctl got=%b exp=%b", a_ctl, C_RUN); else n_pass++; n_checks++;
        tick();
        idle(); #1;
        if (a_stall_cnt !== 16'd2) $display("FAIL lu_a_stall got=%0d exp=2", a_stall_cnt); else n_pass++; n_checks++;
        if (b_stall_cnt !== 4'd2) $display("FAIL lu_b_stall got=%0d exp=2", b_stall_cnt); else n_pass++; n_checks++;
        tick();
    endtask

    task automatic test_branch_jump();
        idle(); ex_branch_taken = 1'b1; id_jump = 1'b1; #1;
        if (a_ctl !== C_BR) $display("FAIL brj_a_ctl got=%b exp=%b", a_ctl, C_BR); else n_pass++; n_checks++;
        if (b_ctl !== C_BR) $display("FAIL brj_b_ctl got=%b exp=%b", b_ctl, C_BR); else n_pass++; n_checks++;
        tick();
        idle(); #1;
        if (a_ctl !== C_DISC) $display("FAIL brj_c1_a_ctl got=%b exp=%b", a_ctl, C_DISC); else n_pass++; n_checks++;
        if (a_fsm_state !== 2'd1) $display("FAIL brj_c1_a_state got=%0d exp=1", a_fsm_state); else n_pass++; n_checks++;
        tick(); #1;
        if (a_ctl !== C_RUN) $display("FAIL brj_c2_a_ctl got=%b exp=%b", a_ctl, C_RUN); else n_pass++; n_checks++;
        if (b_ctl !== C_DISC) $display("FAIL brj_c2_b_ctl got=%b exp=%b", b_ctl, C_DISC); else n_pass++; n_checks++;
        tick(); #1;
        if (b_ctl !== C_RUN) $display("FAIL brj_c3_b_ctl got=%b exp=%b", b_ctl, C_RUN); else n_pass++; n_checks++;
        if (a_flush_cnt !== 16'd3) $display("FAIL brj_a_flush got=%0d exp=3", a_flush_cnt); else n_pass++; n_checks++;
        if (b_flush_cnt !== 4'd5) $display("FAIL brj_b_flush got=%0d exp=5", b_flush_cnt); else n_pass++; n_checks++;
        tick();
    endtask

    task automatic test_mem_busy();
        idle(); id_jump = 1'b1; #1;
        if (a_ctl !== C_JMP) $display("FAIL mb_jump_a_ctl got=%b exp=%b", a_ctl, C_JMP); else n_pass++; n_checks++;
        tick();
        idle(); #1;
        if (b_ctl !== C_DISC) $display("FAIL mb_disc_b_ctl got=%b exp=%b", b_ctl, C_DISC); else n_pass++; n_checks++;
        tick();
        mem_busy = 1'b1; #1;
        if (b_ctl !== C_BUSY) $display("FAIL mb_c0_b_ctl got=%b exp=%b", b_ctl, C_BUSY); else n_pass++; n_checks++;
        if (b_fsm_state !== 2'd1) $display("FAIL mb_c0_b_state got=%0d exp=1", b_fsm_state); else n_pass++; n_checks++;
        for (int i = 1; i < 3; i++) begin
            tick(); #1;
            if (b_ctl !== C_BUSY) $display("FAIL mb_c%0d_b_ctl got=%b exp=%b", i, b_ctl, C_BUSY); else n_pass++; n_checks++;
            if (a_ctl !== C_BUSY) $display("FAIL mb_c%0d_a_ctl got=%b exp=%b", i, a_ctl, C_BUSY); else n_pass++; n_checks++;
            if (b_fsm_state !== 2'd2) $display("FAIL mb_c%0d_b_state got=%0d exp=2", i, b_fsm_state); else n_pass++; n_checks++;
        end
        tick();
        mem_busy = 1'b0; #1;
        if (b_ctl !== C_DISC) $display("FAIL mb_rel_b_ctl got=%b exp=%b", b_ctl, C_DISC); else n_pass++; n_checks++;
        if (a_ctl !== C_RUN) $display("FAIL mb_rel_a_ctl got=%b exp=%b", a_ctl, C_RUN); else n_pass++; n_checks++;
        tick(); #1;
        if (b_ctl !== C_RUN) $display("FAIL mb_after_b_ctl got=%b exp=%b", b_ctl, C_RUN); else n_pass++; n_checks++;
        if (b_fsm_state !== 2'd0) $display("FAIL mb_after_b_state got=%0d exp=0", b_fsm_state); else n_pass++; n_checks++;
        if (a_stall_cnt !== 16'd5) $display("FAIL mb_a_stall got=%0d exp=5", a_stall_cnt); else n_pass++; n_checks++;
        if (b_stall_cnt !== 4'd5) $display("FAIL mb_b_stall got=%0d exp=5", b_stall_cnt); else n_pass++; n_checks++;
        if (b_flush_cnt !== 4'd8) $display("FAIL mb_b_flush got=%0d exp=8", b_flush_cnt); else n_pass++; n_checks++;
        tick();
    endtask

    task automatic test_imem_wait();
        idle(); imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (a_ctl !== C_WAIT) $display("FAIL iw_c%0d_a_ctl got=%b exp=%b", i, a_ctl, C_WAIT); else n_pass++; n_checks++;
            tick();
        end
        imem_ready = 1'b1; #1;
        if (a_ctl !== C_RUN) $display("FAIL iw_resume_a_ctl got=%b exp=%b", a_ctl, C_RUN); else n_pass++; n_checks++;
        if (a_stall_cnt !== 16'd7) $display("FAIL iw_a_stall got=%0d exp=7", a_stall_cnt); else n_pass++; n_checks++;
        if (a_flush_cnt !== 16'd7) $display("FAIL iw_a_flush got=%0d exp=7", a_flush_cnt); else n_pass++; n_checks++;
        if (b_flush_cnt !== 4'd10) $display("FAIL iw_b_flush got=%0d exp=10", b_flush_cnt); else n_pass++; n_checks++;
        tick();
    endtask

    task automatic test_back_to_back();
        idle(); ex_branch_taken = 1'b1; #1;
        if (a_ctl !== C_BR) $display("FAIL b2b_c0_a_ctl got=%b exp=%b", a_ctl, C_BR); else n_pass++; n_checks++;
        tick(); #1;
        if (a_ctl !== C_BR) $display("FAIL b2b_c1_a_ctl got=%b exp=%b", a_ctl, C_BR); else n_pass++; n_checks++;
        if (a_fsm_state !== 2'd1) $display("FAIL b2b_c1_a_state got=%0d exp=1", a_fsm_state); else n_pass++; n_checks++;
        tick();
        idle(); #1;
        if (a_ctl !== C_DISC) $display("FAIL b2b_c2_a_ctl got=%b exp=%b", a_ctl, C_DISC); else n_pass++; n_checks++;
        tick(); #1;
        if (b_ctl !== C_DISC) $display("FAIL b2b_c3_b_ctl got=%b exp=%b", b_ctl, C_DISC); else n_pass++; n_checks++;
        tick(); #1;
        if (b_ctl !== C_RUN) $display("FAIL b2b_c4_b_ctl got=%b exp=%b", b_ctl, C_RUN); else n_pass++; n_checks++;
        if (a_flush_cnt !== 16'd10) $display("FAIL b2b_a_flush got=%0d exp=10", a_flush_cnt); else n_pass++; n_checks++;
        if (b_flush_cnt !== 4'd14) $display("FAIL b2b_b_flush got=%0d exp=14", b_flush_cnt); else n_pass++; n_checks++;
        tick();
    endtask

    task automatic test_saturation();
        idle(); ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (b_ctl !== C_LU) $display("FAIL sat_lu_c%0d_b_ctl got=%b exp=%b", i, b_ctl, C_LU); else n_pass++; n_checks++;
            tick();
        end
        idle(); #1;
        if (a_stall_cnt !== 16'd27) $display("FAIL sat_a_stall got=%0d exp=27", a_stall_cnt); else n_pass++; n_checks++;
        if (b_stall_cnt !== 4'd15) $display("FAIL sat_b_stall got=%0d exp=15", b_stall_cnt); else n_pass++; n_checks++;
        tick();
        imem_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        idle(); #1;
        if (a_flush_cnt !== 16'd16) $display("FAIL sat_a_flush got=%0d exp=16", a_flush_cnt); else n_pass++; n_checks++;
        if (b_flush_cnt !== 4'd15) $display("FAIL sat_b_flush got=%0d exp=15", b_flush_cnt); else n_pass++; n_checks++;
        if (a_stall_cnt !== 16'd33) $display("FAIL sat_a_stall2 got=%0d exp=33", a_stall_cnt); else n_pass++; n_checks++;
        if (b_stall_cnt !== 4'd15) $display("FAIL sat_b_stall2 got=%0d exp=15", b_stall_cnt); else n_pass++; n_checks++;
        tick();
    endtask

    // Time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_load_use();
        test_branch_jump();
        test_mem_busy();
        test_imem_wait();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
